// File: rtl/spiram_bridge.sv
// CPU word port to SPI RAM controller bridge: word reads, per-lane byte writes, busy handshake, gap and arm timeout.
// Optional one-word read cache when SPIRAM_BRIDGE_RDCACHE_EN is defined.
module spiram_bridge #(
  parameter int GAP_CYCLES  = 1,
  parameter int ARM_TIMEOUT = 8
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [19:0] mem_addr,
  input  logic [31:0] mem_wdata,
  input  logic [3:0]  mem_wmask,
  input  logic        mem_rstrb,
  output logic [31:0] mem_rdata,
  output logic        mem_rbusy,
  output logic        mem_wbusy,
  output logic        err,
  output logic        ram_rd,
  output logic        ram_wr,
  output logic [19:0] ram_addr,
  output logic [31:0] ram_wdata,
  input  logic [31:0] ram_rdata,
  input  logic        ram_rbusy,
  input  logic        ram_wbusy
);

  typedef enum logic [2:0] {
    S_IDLE, S_RD_REQ, S_RD_WAIT, S_WR_SCAN, S_WR_REQ, S_WR_WAIT, S_GAP
  } state_t;

  localparam logic [15:0] TMO_LAST = 16'(ARM_TIMEOUT - 1);
  localparam logic [15:0] GAP_LAST = 16'(GAP_CYCLES - 1);

  state_t      r_state, w_next;
  logic [17:0] r_wa;
  logic [31:0] r_wdata;
  logic [3:0]  r_mask;
  logic [1:0]  r_lane;
  logic [31:0] r_rdata;
  logic        r_rbusy, r_wbusy, r_err;
  logic [15:0] r_tmo, r_gap;

  logic       w_wr_acc, w_rd_acc, w_rd_miss, w_hit;
  logic       w_tmo_last, w_gap_done;
  logic       w_rd_to, w_wr_to, w_rd_done, w_wr_ack;
  logic [1:0] w_lane;
  logic       w_unused_addr_lsb;

  assign w_unused_addr_lsb = ^mem_addr[1:0];

`ifdef SPIRAM_BRIDGE_RDCACHE_EN
  logic        r_cvld;
  logic [17:0] r_ctag;
  logic [31:0] r_cdat;
  assign w_hit = r_cvld && (r_ctag == mem_addr[19:2]);
`else
  assign w_hit = 1'b0;
`endif

  assign w_wr_acc   = (r_state == S_IDLE) && (mem_wmask != 4'b0000);
  assign w_rd_acc   = (r_state == S_IDLE) && mem_rstrb && !w_wr_acc;
  assign w_rd_miss  = w_rd_acc && !w_hit;
  assign w_tmo_last = (r_tmo == TMO_LAST);
  assign w_gap_done = (GAP_CYCLES == 0) || (r_gap == GAP_LAST);

  always_comb begin
    w_lane = 2'd0;
    if (r_mask[0])      w_lane = 2'd0;
    else if (r_mask[1]) w_lane = 2'd1;
    else if (r_mask[2]) w_lane = 2'd2;
    else if (r_mask[3]) w_lane = 2'd3;
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) r_state <= S_IDLE;
    else       r_state <= w_next;
  end

  always_comb begin
    w_next    = r_state;
    w_rd_to   = 1'b0;
    w_wr_to   = 1'b0;
    w_rd_done = 1'b0;
    w_wr_ack  = 1'b0;
    case (r_state)
      S_IDLE: begin
        if (w_wr_acc)       w_next = S_WR_SCAN;
        else if (w_rd_miss) w_next = S_RD_REQ;
      end
      S_RD_REQ: begin
        if (ram_rbusy) w_next = S_RD_WAIT;
        else if (w_tmo_last) begin
          w_next  = S_GAP;
          w_rd_to = 1'b1;
        end
      end
      S_RD_WAIT: begin
        if (!ram_rbusy) begin
          w_next    = S_GAP;
          w_rd_done = 1'b1;
        end
      end
      S_WR_SCAN: w_next = (r_mask != 4'b0000) ? S_WR_REQ : S_GAP;
      S_WR_REQ: begin
        if (ram_wbusy) begin
          w_next   = S_WR_WAIT;
          w_wr_ack = 1'b1;
        end else if (w_tmo_last) begin
          w_next  = S_GAP;
          w_wr_to = 1'b1;
        end
      end
      S_WR_WAIT: if (!ram_wbusy) w_next = S_GAP;
      S_GAP: begin
        if (w_gap_done) w_next = (r_mask != 4'b0000) ? S_WR_SCAN : S_IDLE;
      end
      default: w_next = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_wa    <= '0;
      r_wdata <= '0;
      r_mask  <= '0;
      r_lane  <= '0;
      r_rdata <= '0;
      r_rbusy <= 1'b0;
      r_wbusy <= 1'b0;
      r_err   <= 1'b0;
      r_tmo   <= '0;
      r_gap   <= '0;
    end else begin
      r_tmo <= (r_state == S_RD_REQ || r_state == S_WR_REQ) ? r_tmo + 16'd1 : 16'd0;
      r_gap <= (r_state == S_GAP) ? r_gap + 16'd1 : 16'd0;
      if (w_wr_acc) begin
        r_wa    <= mem_addr[19:2];
        r_wdata <= mem_wdata;
        r_mask  <= mem_wmask;
        r_wbusy <= 1'b1;
      end else if (w_rd_miss) begin
        r_wa    <= mem_addr[19:2];
        r_rbusy <= 1'b1;
      end
`ifdef SPIRAM_BRIDGE_RDCACHE_EN
      if (w_rd_acc && w_hit) r_rdata <= r_cdat;
`endif
      if (r_state == S_WR_SCAN) r_lane <= w_lane;
      if (w_wr_ack) r_mask[r_lane] <= 1'b0;
      if (w_rd_done) r_rdata <= ram_rdata;
      if (w_rd_to) begin
        r_err   <= 1'b1;
        r_rdata <= 32'hFFFF_FFFF;
      end
      // A write timeout drops every lane still pending.
      if (w_wr_to) begin
        r_err  <= 1'b1;
        r_mask <= 4'b0000;
      end
      if (r_state == S_GAP && w_gap_done && r_mask == 4'b0000) begin
        r_rbusy <= 1'b0;
        r_wbusy <= 1'b0;
      end
    end
  end

`ifdef SPIRAM_BRIDGE_RDCACHE_EN
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_cvld <= 1'b0;
      r_ctag <= '0;
      r_cdat <= '0;
    end else begin
      if (w_wr_acc && w_hit) begin
        for (int i = 0; i < 4; i++)
          if (mem_wmask[i]) r_cdat[8*i +: 8] <= mem_wdata[8*i +: 8];
      end
      if (w_rd_done) begin
        r_cvld <= 1'b1;
        r_ctag <= r_wa;
        r_cdat <= ram_rdata;
      end
      if (w_rd_to || w_wr_to) r_cvld <= 1'b0;
    end
  end
`endif

  assign mem_rdata = r_rdata;
  assign mem_rbusy = r_rbusy;
  assign mem_wbusy = r_wbusy;
  assign err       = r_err;
  assign ram_rd    = (r_state == S_RD_REQ);
  assign ram_wr    = (r_state == S_WR_REQ);
  assign ram_addr  = (r_state == S_RD_REQ) ? {r_wa, 2'b00} :
                     (r_state == S_WR_REQ) ? {r_wa, r_lane} : 20'h0;
  assign ram_wdata = (r_state == S_WR_REQ) ? {24'h0, r_wdata[{r_lane, 3'b000} +: 8]} : 32'h0;

endmodule

// File: doc/spiram_bridge.md
# spiram_bridge

Byte-lane bridge between the CPU memory port and the SPI RAM controller. Converts one CPU word request (32-bit read, or masked write with 1-4 byte lanes) into a sequence of controller transactions: one word read, or one single-byte write per enabled lane. Handles the controller's request/busy handshake and inter-transaction gap. Sits directly upstream of the SPI RAM controller.

## Interface
Parameters:
- GAP_CYCLES, 1, idle cycles inserted after a controller busy falls before the next ram_rd/ram_wr
- ARM_TIMEOUT, 8, max cycles to wait for controller busy to rise after a request before flagging error

Ports (one clock; reset is asynchronous and active-high):
- clk  in  1  system clock
- reset  in  1  asynchronous, active-high reset
- mem_addr  in  20  CPU byte address; bits [1:0] ignored
- mem_wdata  in  32  CPU write data, lane n = bits [8n+7:8n]
- mem_wmask  in  4  byte-lane write enables; nonzero = write request
- mem_rstrb  in  1  read request strobe (one cycle)
- mem_rdata  out  32  read data, registered
- mem_rbusy  out  1  read in progress
- mem_wbusy  out  1  write in progress
- err  out  1  sticky: controller never acknowledged a request; cleared by reset
- ram_rd  out  1  controller read request
- ram_wr  out  1  controller byte-write request
- ram_addr  out  20  controller byte address
- ram_wdata  out  32  controller write data; byte in [7:0], [31:8] = 0
- ram_rdata  in  32  controller read word
- ram_rbusy  in  1  controller read busy
- ram_wbusy  in  1  controller write busy

## Operation
- States: IDLE, RD_REQ, RD_WAIT, WR_SCAN, WR_REQ, WR_WAIT, GAP.
- IDLE: mem_wmask != 0 -> latch addr/wdata/wmask, mem_wbusy=1, go WR_SCAN. Else mem_rstrb -> latch addr, mem_rbusy=1, go RD_REQ. Both in same cycle: write wins, read dropped. Requests outside IDLE ignored.
- RD_REQ: ram_rd=1, ram_addr={addr[19:2],2'b00}; held until ram_rbusy seen high, then ram_rd=0, go RD_WAIT. No busy within ARM_TIMEOUT cycles: set err, mem_rdata=32'hFFFF_FFFF, go GAP.
- RD_WAIT: on ram_rbusy low, mem_rdata<=ram_rdata, go GAP.
- WR_SCAN: pick lowest set bit n of remaining mask; none left -> GAP.
- WR_REQ: ram_wr=1, ram_addr={addr[19:2],n[1:0]}, ram_wdata={24'h0, lane n}; held until ram_wbusy high, then clear bit n, go WR_WAIT. Timeout: set err, abandon remaining lanes, go GAP.
- WR_WAIT: on ram_wbusy low -> GAP (flag that returns to WR_SCAN).
- GAP: count GAP_CYCLES; then return to WR_SCAN if lanes remain, else clear mem_rbusy/mem_wbusy, go IDLE.
- ram_rd and ram_wr never high together; never high in GAP or IDLE.

## Timing
- Reset: state IDLE, mem_rdata=0, mem_rbusy=0, mem_wbusy=0, err=0, ram_rd=0, ram_wr=0, ram_addr=0, ram_wdata=0, lane mask 0, cache invalid.
- mem_rbusy/mem_wbusy rise the cycle after acceptance; CPU samples mem_rdata only after mem_rbusy falls.
- Read miss latency = 1 + (request-to-busy) + busy length + GAP_CYCLES + 1.
- Write with k lanes = k controller transactions, each followed by GAP_CYCLES; wmask=4'b0000 never starts a write.
- Reset mid-transaction: immediate return to IDLE, requests dropped, partial writes not rolled back.

## Configuration
- SPIRAM_BRIDGE_RDCACHE_EN defined: one-word read cache (tag addr[19:2], 32-bit data, valid). Read hit: no controller traffic, mem_rbusy stays 0, mem_rdata valid next cycle. Miss fill on RD_WAIT completion. Writes to cached word update enabled lanes in cache (write-through). Timeout invalidates.
- Undefined: every read goes to controller; no cache state exists.

## Test plan
- Read 0x00124, controller model returns 32'hDEADBEEF after 6-cycle busy -> ram_addr=0x00124, one ram_rd, mem_rdata=32'hDEADBEEF, mem_rbusy low after GAP.
- Write addr 0x00100, wmask=4'b1010, wdata=32'h11223344 -> two ram_wr: addr 0x00101 data 0x33, then 0x00103 data 0x11, GAP_CYCLES idle between, mem_wbusy spans both.
- Same-cycle wmask=4'b0001 and mem_rstrb -> only one write, zero ram_rd.
- Controller never raises busy -> after ARM_TIMEOUT cycles err=1, mem_rdata=32'hFFFFFFFF, bridge back in IDLE.
- Reset asserted during WR_WAIT of 4-lane write -> all outputs at reset values same cycle; no further ram_wr.
- With SPIRAM_BRIDGE_RDCACHE_EN: read 0x200 twice, write 0x201 wmask=4'b0001 data 0xAA, read 0x200 -> second read no ram_rd, third returns byte0 = 0xAA without ram_rd.
